// File: rtl/jtframe_spi_dwnld.sv
// jtframe_spi_dwnld: replays an image store to a core over a bit-banged SPI link (index, tx-on, data, tx-off frames)
module jtframe_spi_dwnld #(
  parameter int SLOTS  = 4,
  parameter int AW     = 25,
  parameter int CLKDIV = 4,
  parameter int GAP    = 8,
  localparam int SW    = SLOTS > 1 ? $clog2(SLOTS) : 1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] slot,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] rd_addr,
  output logic          rd_req,
  input  logic [7:0]    rd_data,
  input  logic          rd_ok,
  output logic          SPI_SCK,
  output logic          SPI_DI,
  output logic          SPI_SS2,
  output logic          busy,
  output logic          done
);
  localparam int CM = CLKDIV > GAP ? CLKDIV : GAP;
  localparam int CW = $clog2(CM + 1);
  typedef enum logic [2:0] {IDLE, IDX, TXON, DATA, TXOFF, DONE} state_t;
  typedef enum logic [2:0] {P_LO, P_HI, P_WAIT, P_POST, P_GAP} phase_t;
  state_t        state, state_nx;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh, nxt, cmd, sec;
  logic          nv, load, fe, in_frame, half;
  logic [AW-1:0] len_q, bleft, fcnt;
  logic [SW-1:0] slot_c;
  assign SPI_DI   = sh[7];
  assign slot_c   = 32'(slot) >= SLOTS ? SW'(SLOTS - 1) : slot;
  assign half     = cnt == CW'(CLKDIV - 1);
  assign fe       = phase == P_GAP && cnt == CW'(GAP - 1);
  assign in_frame = state != IDLE && state != DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? IDX : IDLE;
      IDX:     state_nx = fe ? TXON : IDX;
      TXON:    state_nx = fe ? (len_q == '0 ? TXOFF : DATA) : TXON;
      DATA:    state_nx = fe ? TXOFF : DATA;
      TXOFF:   state_nx = fe ? DONE : TXOFF;
      default: state_nx = IDLE;
    endcase
    load = state_nx != state && state_nx != IDLE && state_nx != DONE;
    cmd  = state_nx == IDX ? 8'h55 : state_nx == DATA ? 8'h53 : 8'h54;
    sec  = state_nx == IDX ? 8'(slot_c) : state_nx == TXON ? 8'hFF : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase   <= P_LO;
      cnt     <= '0;
      bitn    <= '0;
      sh      <= '0;
      nxt     <= '0;
      nv      <= 1'b0;
      len_q   <= '0;
      bleft   <= '0;
      fcnt    <= '0;
      rd_addr <= '0;
      rd_req  <= 1'b0;
      SPI_SCK <= 1'b0;
      SPI_SS2 <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= state_nx == DONE;
      busy <= state_nx != IDLE;
      if (state == IDLE && start) len_q <= len;
      if (load) begin
        SPI_SS2 <= 1'b0;
        SPI_SCK <= 1'b0;
        sh      <= cmd;
        nxt     <= sec;
        nv      <= state_nx != DATA;
        bleft   <= state_nx == DATA ? len_q : AW'(1);
        bitn    <= '0;
        cnt     <= '0;
        fcnt    <= '0;
        rd_req  <= 1'b0;
        phase   <= P_LO;
      end else if (in_frame) begin
        case (phase)
          P_LO: if (half) begin
            SPI_SCK <= 1'b1;
            cnt     <= '0;
            phase   <= P_HI;
          end else cnt <= cnt + 1'b1;
          P_HI: if (half) begin
            SPI_SCK <= 1'b0;
            cnt     <= '0;
            if (bitn != 3'd7) begin
              bitn  <= bitn + 1'b1;
              sh    <= sh << 1;
              phase <= P_LO;
            end else if (bleft == '0) phase <= P_POST;
            else begin
              bitn  <= '0;
              bleft <= bleft - 1'b1;
              phase <= nv ? P_LO : P_WAIT;
              if (nv) begin
                sh <= nxt;
                nv <= 1'b0;
              end
            end
          end else cnt <= cnt + 1'b1;
          // byte due but not fetched yet: SCK parks low until the store answers
          P_WAIT: if (nv) begin
            sh    <= nxt;
            nv    <= 1'b0;
            phase <= P_LO;
          end
          P_POST: if (half) begin
            SPI_SS2 <= 1'b1;
            cnt     <= '0;
            phase   <= P_GAP;
          end else cnt <= cnt + 1'b1;
          default: cnt <= cnt + 1'b1;
        endcase
        if (rd_req && rd_ok) begin
          nxt    <= rd_data;
          nv     <= 1'b1;
          rd_req <= 1'b0;
        end else if (state == DATA && !nv && !rd_req && fcnt < len_q && phase != P_POST && phase != P_GAP) begin
          rd_req  <= 1'b1;
          rd_addr <= fcnt;
          fcnt    <= fcnt + 1'b1;
        end
      end
    end
endmodule

// File: doc/jtframe_spi_dwnld.md
JTFRAME_SPI_DWNLD -- requirements
Module: jtframe_spi_dwnld

Interface
REQ-001 SHALL have parameter SLOTS, default 4: number of selectable download images (index 0..SLOTS-1).
REQ-002 SHALL have parameter AW, default 25: byte-address and length width.
REQ-003 SHALL have parameter CLKDIV, default 4: SCK half-period in clk cycles (>=1).
REQ-004 SHALL have parameter GAP, default 8: clk cycles SPI_SS2 held high between frames (>=1).
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle download request, sampled only in IDLE.
REQ-008 slot  in  $clog2(SLOTS)  image index, latched with start.
REQ-009 len  in  AW  byte count, latched with start.
REQ-010 rd_addr  out  AW  byte address requested from image store.
REQ-011 rd_req  out  1  request strobe; held until rd_ok.
REQ-012 rd_data  in  8  byte returned; valid when rd_ok.
REQ-013 rd_ok  in  1  one-cycle acknowledge, any latency >=0 cycles after rd_req.
REQ-014 SPI_SCK  out  1  serial clock, idle low.
REQ-015 SPI_DI  out  1  serial data to core, MSB first.
REQ-016 SPI_SS2  out  1  active-low frame select.
REQ-017 busy  out  1  high from start accept until DONE exit.
REQ-018 done  out  1  one-cycle pulse on completion.

Function
REQ-019 SHALL sequence states IDLE -> IDX -> TXON -> DATA -> TXOFF -> DONE -> IDLE; each of IDX/TXON/TXOFF is one SS2 frame of two bytes; DATA is one frame of 1+len bytes.
REQ-020 IDX frame SHALL send 0x55 then slot byte (zero-extended); TXON SHALL send 0x54, 0xFF; TXOFF SHALL send 0x54, 0x00; DATA SHALL send 0x53 then image bytes addr 0..len-1 in order.
REQ-021 len==0 SHALL skip DATA entirely (TXON frame directly followed by TXOFF frame).
REQ-022 slot>=SLOTS SHALL be clamped to SLOTS-1.
REQ-023 Bit timing: SPI_DI SHALL change only while SCK low; SCK SHALL be low CLKDIV cycles then high CLKDIV cycles per bit; 8 bits per byte, no gap between bytes in a frame.
REQ-024 SS2 SHALL fall CLKDIV cycles before first SCK rise of a frame and rise CLKDIV cycles after last SCK fall; then stay high GAP cycles before next frame.
REQ-025 Image byte N SHALL be fetched (rd_req, rd_addr=N) during byte N-1 shift (or during the 0x53 command for N=0); if rd_ok not yet received when the byte is due, SCK SHALL stall low with SS2 held low until rd_ok.
REQ-026 rd_addr SHALL be AW bits; no wrap, since len<2^AW; len=2^AW-1 SHALL end at address 2^AW-2.
REQ-027 start while busy SHALL be ignored; start and done in the same cycle: start ignored.
REQ-028 done SHALL pulse exactly once, the cycle DONE is entered; busy SHALL drop the following cycle.
REQ-029 rd_ok without outstanding rd_req SHALL be ignored.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, SPI_SCK=0, SPI_DI=0, SPI_SS2=1, rd_req=0, rd_addr=0, busy=0, done=0, counters cleared.
REQ-031 Reset mid-transfer SHALL abort without completing the frame; after release, block SHALL accept a new start normally.
REQ-032 Outputs SHALL be registered; no combinational path from inputs to SPI pins.

Verification
REQ-033 start, slot=2, len=3, bytes A1 B2 C3, rd_ok 1 cycle after rd_req -> SPI decoder captures frames {55 02}{54 FF}{53 A1 B2 C3}{54 00}; one done pulse.
REQ-034 len=0, slot=0 -> frames {55 00}{54 FF}{54 00}; rd_req never asserted.
REQ-035 CLKDIV=1, rd_ok delayed 20 cycles on byte 1 -> SCK held low 20+ cycles with SS2 low; captured data unchanged.
REQ-036 start pulsed again mid-DATA -> ignored; single done; frame count 4.
REQ-037 rst_n low during byte 2 of DATA -> SS2=1, SCK=0, busy=0 immediately; new start then yields full correct frame sequence.
REQ-038 slot=7 with SLOTS=4 -> IDX frame sends {55 03}; checker asserts SS2 high >=GAP cycles between all frames.
